cfg_chain_sequencer: RTL
========================

Name: cfg_chain_sequencer

Overview:
- Streams configuration words from the Wishbone configurator into the per-column CLB configuration chains of one config region (NUM_COLS columns).
- Each chain step moves one bit per column. The block drives that column's cen, its shift line (serial data) and its set line (commit strobe).
- Sits between one configuration region's Wishbone slave logic and the bottom row of CLB tiles.
- Replaces the direct register-driven bit-banging of set/shift with a hardware sequencer that handles flow control.

Parameters:
- NUM_COLS, 4, columns driven by this region; one chain bit per column per step.
- WORD_W, 32, input config word width; must be a multiple of NUM_COLS.
- CHAIN_LEN, 256, shift steps per column per full load; must be a multiple of WORD_W/NUM_COLS.
- CNT_W, $clog2(CHAIN_LEN+1), step counter width.

Ports:
- clk  input  1  fabric/Wishbone clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a load when IDLE
- abort  input  1  one-cycle pulse; cancels a load in progress
- col_mask  input  NUM_COLS  columns to load; sampled on accepted start
- word_valid  input  1  config word available
- word_data  input  WORD_W  config word
- word_ready  output  1  word accepted when valid && ready
- cen  output  NUM_COLS  per-column config clock enable
- shift_out  output  NUM_COLS  per-column serial config bit
- set_out  output  NUM_COLS  per-column commit strobe
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse when a load completes
- aborted  output  1  one-cycle pulse when a load is cancelled
- steps_done  output  CNT_W  shift steps completed in the current or last load

Behaviour:
- Clocking and reset: single clock. Asynchronous active-low reset (rst_n).
- Reset values: all outputs 0. State IDLE, counters 0, mask register 0, word buffer empty.
- States: IDLE, FETCH, SHIFT, SET, FINISH.
- IDLE:
  - word_ready=0.
  - On start: latch col_mask into mask_q, clear steps_done, go to FETCH.
  - If col_mask==0 on start: go straight to FINISH (done pulse, no chain activity).
- FETCH:
  - word_ready=1.
  - On handshake: load word_data into the shift buffer, set beat=0, go to SHIFT.
  - While word_valid=0: stay in FETCH; cen=0 (chains hold).
- SHIFT, per cycle:
  - shift_out[i] = buf[beat*NUM_COLS+i] & mask_q[i].
  - cen = mask_q.
  - beat and steps_done increment.
- SHIFT exit conditions:
  - Buffer exhausted (beat==WORD_W/NUM_COLS-1) and steps_done+1<CHAIN_LEN: return to FETCH.
  - steps_done+1==CHAIN_LEN: go to SET.
- Ordering: LSB-first. Word bits [NUM_COLS-1:0] are the first step; word 0 is the first word.
- Prefetch: word_ready is also high in the last beat of SHIFT when more words are needed. An accepted word loads directly, so back-to-back words give continuous shifting with no bubble.
- SET: one cycle. set_out=mask_q, cen=mask_q, shift_out=0. Go to FINISH.
- FINISH: one cycle. done=1, then IDLE. steps_done holds its final value until the next start.
- Latency: with word_valid held high, start to done = 1 + CHAIN_LEN + (first FETCH) + 1 (SET) + 1 cycles.
  - Example: CHAIN_LEN=16, NUM_COLS=4, WORD_W=32 gives 20 cycles.
- Outputs are registered. cen/shift_out/set_out change only on clk edges and never glitch.
- Boundary and corner cases:
  - start while busy: ignored.
  - abort in IDLE: ignored.
  - abort in FETCH/SHIFT/SET: next state IDLE; cen/shift_out/set_out=0 next cycle; aborted pulses; set_out never asserts. A word handshaking in the same cycle as abort is consumed and discarded.
  - abort and start in the same cycle while IDLE: start wins.
  - abort in FINISH: ignored; done still pulses.
  - Reset mid-load: outputs drop asynchronously to 0. Chain contents are undefined; software must reload.
  - word_valid in IDLE/SET/FINISH: word_ready=0; the word is not consumed.

Decomposition:
- Shared package cfg_pkg:
  - state enum (IDLE, FETCH, SHIFT, SET, FINISH);
  - localparam BEATS_PER_WORD = WORD_W/NUM_COLS;
  - elaboration checks for the divisibility rules.
- One natural sub-module, cfg_word_serializer: the word buffer plus beat counter.
  - Interface: load, advance, last_beat, bits[NUM_COLS-1:0].
  - The FSM and counters stay in cfg_chain_sequencer.

Test Plan (NUM_COLS=4, WORD_W=32, CHAIN_LEN=16):
- Basic load:
  - Stimulus: mask=4'hF, words 32'h87654321 then 32'h0FEDCBA9, valid held high.
  - Required: shift_out sequence 1,2,3,4,5,6,7,8,9,A,B,C,D,E,F,0 over 16 cycles with cen=4'hF; one set_out=4'hF cycle; done 20 cycles after start; steps_done=16.
- Stall:
  - Stimulus: same load, word_valid low for 5 cycles between the two words.
  - Required: cen=0 for exactly those cycles; identical bit sequence; done at cycle 25.
- Masked columns:
  - Stimulus: mask=4'b0101, word 32'hFFFFFFFF twice.
  - Required: cen=4'b0101, shift_out=4'b0101 every step, set_out=4'b0101.
- Abort:
  - Stimulus: abort at step 5.
  - Required: aborted pulse; set_out never asserts; busy=0 next cycle; steps_done=5; a following start runs a full 16-step load correctly.
- Reset mid-SHIFT:
  - Stimulus: rst_n low asynchronously mid-SHIFT.
  - Required: all outputs 0 immediately; after release, state IDLE and word_ready=0.
- Edge cases:
  - Stimulus: start with mask=0; separately, start while busy.
  - Required: mask=0 gives done the next cycle with no cen activity; start while busy leaves the sequence undisturbed.

Source files
------------

// File: rtl/cfg_pkg.sv
// cfg_pkg: shared state encoding, default sizing and parameter checks for the config chain sequencer
// Contents: state_t (sequencer FSM states), DEF_* default sizes,
//           beats_per_word() chain steps per config word,
//           cfg_params_ok() divisibility rules for a legal configuration.
package cfg_pkg;
  localparam int DEF_NUM_COLS  = 4;
  localparam int DEF_WORD_W    = 32;
  localparam int DEF_CHAIN_LEN = 256;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_SET    = 3'd3,
    ST_FINISH = 3'd4
  } state_t;
  function automatic int beats_per_word(input int word_w, input int num_cols);
    return word_w / num_cols;
  endfunction
  function automatic bit cfg_params_ok(input int num_cols, input int word_w, input int chain_len);
    return num_cols > 0 && word_w >= num_cols && word_w % num_cols == 0 &&
           chain_len > 0 && chain_len % (word_w / num_cols) == 0;
  endfunction
endpackage

// File: rtl/cfg_word_serializer.sv
// cfg_word_serializer: holds one config word and presents it NUM_COLS bits per beat, LSB first
// Ports: clk, rst_n     clock, asynchronous active-low reset
//        load, data     capture a new word and restart at beat 0 (wins over advance)
//        advance        move to the next beat
//        bits           current beat's slice of the word
//        last_beat      current beat is the final slice of the word
module cfg_word_serializer
  import cfg_pkg::*;
#(
  parameter int NUM_COLS = DEF_NUM_COLS,
  parameter int WORD_W   = DEF_WORD_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [WORD_W-1:0]   data,
  input  logic                advance,
  output logic [NUM_COLS-1:0] bits,
  output logic                last_beat
);
  localparam int BEATS_PER_WORD = beats_per_word(WORD_W, NUM_COLS);
  localparam int BW = BEATS_PER_WORD > 1 ? $clog2(BEATS_PER_WORD) : 1;
  logic [WORD_W-1:0] r_buf;
  logic [BW-1:0]     r_beat;
  assign last_beat = r_beat == BW'(BEATS_PER_WORD - 1);
  assign bits      = r_buf[r_beat*NUM_COLS +: NUM_COLS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_buf  <= '0;
      r_beat <= '0;
    end else if (load) begin
      r_buf  <= data;
      r_beat <= '0;
    end else if (advance)
      r_beat <= last_beat ? '0 : r_beat + 1'b1;
endmodule

// File: rtl/cfg_chain_sequencer.sv
// cfg_chain_sequencer: streams Wishbone config words into the per-column CLB configuration chains
// Ports: clk, rst_n               clock, asynchronous active-low reset
//        start, abort, col_mask   begin a load on the masked columns / cancel a load
//        word_valid/ready/data    config word stream, accepted on valid && ready
//        cen, shift_out, set_out  per-column chain enable, serial bit and commit strobe (registered)
//        busy, done, aborted      status: not idle / load complete pulse / load cancelled pulse
//        steps_done               shift steps completed in the current or last load
module cfg_chain_sequencer
  import cfg_pkg::*;
#(
  parameter int NUM_COLS  = DEF_NUM_COLS,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [NUM_COLS-1:0] col_mask,
  input  logic                word_valid,
  input  logic [WORD_W-1:0]   word_data,
  output logic                word_ready,
  output logic [NUM_COLS-1:0] cen,
  output logic [NUM_COLS-1:0] shift_out,
  output logic [NUM_COLS-1:0] set_out,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [CNT_W-1:0]    steps_done
);
  if (!cfg_params_ok(NUM_COLS, WORD_W, CHAIN_LEN)) begin : g_bad_params
    $error("cfg_chain_sequencer: WORD_W must be a multiple of NUM_COLS and CHAIN_LEN a multiple of WORD_W/NUM_COLS");
  end
  state_t              r_state, w_next;
  logic [NUM_COLS-1:0] r_mask, r_cen, r_shift, r_set, w_bits;
  logic [CNT_W-1:0]    r_steps;
  logic                r_done, r_aborted, r_busy;
  logic                w_last_beat, w_last_step, w_hs, w_abort, w_step, w_set;
  cfg_word_serializer #(.NUM_COLS(NUM_COLS), .WORD_W(WORD_W)) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_hs),
    .data     (word_data),
    .advance  (w_step),
    .bits     (w_bits),
    .last_beat(w_last_beat)
  );
  assign w_last_step = r_steps == CNT_W'(CHAIN_LEN - 1);
  // Prefetch: ask for the next word during the final beat so back-to-back words shift without a bubble.
  assign word_ready  = r_state == ST_FETCH || (r_state == ST_SHIFT && w_last_beat && !w_last_step);
  // A word accepted in the same cycle as abort still loads the buffer; the FSM simply discards it.
  assign w_hs        = word_valid && word_ready;
  assign w_abort     = abort && (r_state == ST_FETCH || r_state == ST_SHIFT || r_state == ST_SET);
  assign w_step      = r_state == ST_SHIFT && !abort;
  assign w_set       = r_state == ST_SET && !abort;
  always_comb
    w_next = r_state == ST_IDLE  ? (start ? (col_mask == '0 ? ST_FINISH : ST_FETCH) : ST_IDLE) :
             w_abort             ? ST_IDLE :
             r_state == ST_FETCH ? (w_hs ? ST_SHIFT : ST_FETCH) :
             r_state == ST_SHIFT ? (w_last_step ? ST_SET : (w_last_beat && !w_hs) ? ST_FETCH : ST_SHIFT) :
             r_state == ST_SET   ? ST_FINISH : ST_IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_mask    <= '0;
      r_steps   <= '0;
      r_cen     <= '0;
      r_shift   <= '0;
      r_set     <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_next;
      if (r_state == ST_IDLE && start) begin
        r_mask  <= col_mask;
        r_steps <= '0;
      end else if (w_step)
        r_steps <= r_steps + 1'b1;
      // Chain outputs register the action of the current state, so they trail the FSM by one cycle.
      r_cen     <= (w_step || w_set) ? r_mask : '0;
      r_shift   <= w_step ? (w_bits & r_mask) : '0;
      r_set     <= w_set ? r_mask : '0;
      r_done    <= r_state == ST_FINISH;
      r_aborted <= w_abort;
      r_busy    <= w_next != ST_IDLE;
    end
  assign cen        = r_cen;
  assign shift_out  = r_shift;
  assign set_out    = r_set;
  assign busy       = r_busy;
  assign done       = r_done;
  assign aborted    = r_aborted;
  assign steps_done = r_steps;
endmodule
